// File: rtl/id_scoreboard_pkg.sv
// Shared constants and types for the Decode-stage register scoreboard.
package id_scoreboard_pkg;

    localparam int REG_CNT = 32;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_DRAIN = 2'd1,
        SB_ACK   = 2'd2
    } sb_state_e;

    function automatic logic tracked(input logic [4:0] idx, input logic en);
        return en & (idx != 5'd0);
    endfunction

endpackage

// File: rtl/id_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic max,
    output logic zero_next,
    output logic underflow
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_ok;
    logic             inc_ok;

    // A release on an empty counter is ignored; an increment never wraps.
    always_comb begin
        dec_ok = dec & (cnt_q != '0);
        inc_ok = inc & ((cnt_q != '1) | dec_ok);
        cnt_d  = cnt_q;
        if (inc_ok & ~dec_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_ok & ~inc_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero      = (cnt_q == '0);
    assign max       = (cnt_q == '1);
    assign zero_next = (cnt_d == '0);
    assign underflow = dec & (cnt_q == '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register hazard scoreboard with fence/drain sequencing.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_id_valid,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_wr,
    input  logic        i_ex_stall,
    input  logic        i_rel_valid,
    input  logic [4:0]  i_rel_rd,
    input  logic        i_fence_req,
    output logic        o_stall,
    output logic        o_issue,
    output logic        o_fence_ack,
    output logic        o_busy,
    output logic [31:0] o_pending,
    output logic        o_underflow
);

    logic [REG_CNT-1:0] zero_v;
    logic [REG_CNT-1:0] max_v;
    logic [REG_CNT-1:0] zn_v;
    logic [REG_CNT-1:0] uf_v;

    assign zero_v[0] = 1'b1;
    assign max_v[0]  = 1'b0;
    assign zn_v[0]   = 1'b1;
    assign uf_v[0]   = 1'b0;

    for (genvar r = 1; r < REG_CNT; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (o_issue & i_rd_wr & (i_rd == 5'(r))),
            .dec       (i_rel_valid & (i_rel_rd == 5'(r))),
            .zero      (zero_v[r]),
            .max       (max_v[r]),
            .zero_next (zn_v[r]),
            .underflow (uf_v[r])
        );
    end

    sb_state_e state_q, state_d;
    logic      armed_q, armed_d;
    logic      uf_q, uf_d;
    logic      hazard;

    always_comb begin
        hazard = (tracked(i_rs1, i_rs1_used) & ~zero_v[i_rs1])
               | (tracked(i_rs2, i_rs2_used) & ~zero_v[i_rs2])
               | (tracked(i_rd, i_rd_wr) & max_v[i_rd]);
    end

    assign o_stall = i_id_valid
                   & (hazard | (state_q != SB_IDLE) | i_fence_req);
    assign o_issue = i_id_valid & ~o_stall & ~i_ex_stall;

    // A request still high when the ack fires must drop before re-arming.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        uf_d    = uf_q | (|uf_v);
        if (!i_fence_req) begin
            armed_d = 1'b1;
        end else if (state_q == SB_ACK) begin
            armed_d = 1'b0;
        end
        unique case (state_q)
            SB_IDLE:  if (i_fence_req & armed_q) state_d = SB_DRAIN;
            SB_DRAIN: if (&zn_v) state_d = SB_ACK;
            SB_ACK:   state_d = SB_IDLE;
            default:  state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_IDLE;
            armed_q <= 1'b1;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            uf_q    <= uf_d;
        end
    end

    assign o_fence_ack = (state_q == SB_ACK);
    assign o_pending   = ~zero_v;
    assign o_busy      = |o_pending;
    assign o_underflow = uf_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with a per-register count model.
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_id_valid;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        i_rs1_used;
    logic        i_rs2_used;
    logic [4:0]  i_rd;
    logic        i_rd_wr;
    logic        i_ex_stall;
    logic        i_rel_valid;
    logic [4:0]  i_rel_rd;
    logic        i_fence_req;
    logic        o_stall;
    logic        o_issue;
    logic        o_fence_ack;
    logic        o_busy;
    logic [31:0] o_pending;
    logic        o_underflow;

    always #5 clk = ~clk;

    id_scoreboard #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_id_valid  (i_id_valid),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_rs1_used  (i_rs1_used),
        .i_rs2_used  (i_rs2_used),
        .i_rd        (i_rd),
        .i_rd_wr     (i_rd_wr),
        .i_ex_stall  (i_ex_stall),
        .i_rel_valid (i_rel_valid),
        .i_rel_rd    (i_rel_rd),
        .i_fence_req (i_fence_req),
        .o_stall     (o_stall),
        .o_issue     (o_issue),
        .o_fence_ack (o_fence_ack),
        .o_busy      (o_busy),
        .o_pending   (o_pending),
        .o_underflow (o_underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int acks  = 0;

    // Model: outstanding writes per register, fence phase, sticky error.
    int m_cnt[32];
    bit m_uf      = 1'b0;
    int m_phase   = 0;
    bit m_armed   = 1'b1;
    bit started   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        return (i_rs1_used && i_rs1 != 0 && m_cnt[i_rs1] != 0)
            || (i_rs2_used && i_rs2 != 0 && m_cnt[i_rs2] != 0)
            || (i_rd_wr && i_rd != 0 && m_cnt[i_rd] == 3);
    endfunction

    function automatic bit m_stall();
        return i_id_valid && (m_hazard() || m_phase != 0 || i_fence_req);
    endfunction

    function automatic bit m_issue();
        return i_id_valid && !m_stall() && !i_ex_stall;
    endfunction

    always @(negedge clk) begin
        logic [31:0] pend;
        if (!rst && started) begin
            pend = '0;
            for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) pend[r] = 1'b1;
            chk("m_stall", 32'(o_stall), 32'(m_stall()));
            chk("m_issue", 32'(o_issue), 32'(m_issue()));
            chk("m_ack", 32'(o_fence_ack), 32'(m_phase == 2));
            chk("m_busy", 32'(o_busy), 32'(pend != 0));
            chk("m_pending", o_pending, pend);
            chk("m_underflow", 32'(o_underflow), 32'(m_uf));
            if (o_fence_ack) acks++;
        end
    end

    always @(posedge clk) begin
        int pre_rel;
        int tot;
        int old_phase;
        bit iss;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_uf    = 1'b0;
            m_phase = 0;
            m_armed = 1'b1;
            started = 1'b1;
        end else begin
            iss     = m_issue();
            pre_rel = m_cnt[i_rel_rd];
            if (iss && i_rd_wr && i_rd != 0 && m_cnt[i_rd] < 3)
                m_cnt[i_rd]++;
            if (i_rel_valid && i_rel_rd != 0) begin
                if (pre_rel == 0) m_uf = 1'b1;
                else m_cnt[i_rel_rd]--;
            end
            tot = 0;
            for (int r = 1; r < 32; r++) tot += m_cnt[r];
            old_phase = m_phase;
            if (old_phase == 0 && i_fence_req && m_armed) m_phase = 1;
            else if (old_phase == 1 && tot == 0) m_phase = 2;
            else if (old_phase == 2) m_phase = 0;
            if (!i_fence_req) m_armed = 1'b1;
            else if (old_phase == 2) m_armed = 1'b0;
        end
    end

    task automatic clr();
        i_id_valid  = 0; i_rs1 = 0; i_rs2 = 0; i_rs1_used = 0;
        i_rs2_used  = 0; i_rd = 0; i_rd_wr = 0; i_ex_stall = 0;
        i_rel_valid = 0; i_rel_rd = 0; i_fence_req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    int a0;

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        i_id_valid = 1;
        at_neg();
        chk("rst_pending", o_pending, 32'h0);
        chk("rst_issue", 32'(o_issue), 32'd1);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_uf", 32'(o_underflow), 32'd0);
        chk("rst_ack", 32'(o_fence_ack), 32'd0);
        step();

        // Back-to-back RAW on x5
        clr(); i_id_valid = 1; i_rd = 5; i_rd_wr = 1;
        at_neg(); chk("raw_issue", 32'(o_issue), 32'd1);
        step();
        clr(); i_id_valid = 1; i_rs1 = 5; i_rs1_used = 1;
        at_neg();
        chk("raw_stall", 32'(o_stall), 32'd1);
        chk("raw_pending", o_pending, 32'h0000_0020);
        step();
        i_rel_valid = 1; i_rel_rd = 5;
        at_neg(); chk("raw_nobypass", 32'(o_stall), 32'd1);
        step();
        i_rel_valid = 0;
        at_neg();
        chk("raw_release_stall", 32'(o_stall), 32'd0);
        chk("raw_release_issue", 32'(o_issue), 32'd1);
        step();

        // x0 immunity
        clr(); i_id_valid = 1; i_rd = 0; i_rd_wr = 1;
        repeat (3) begin
            at_neg(); chk("x0_issue", 32'(o_issue), 32'd1);
            step();
        end
        clr(); i_id_valid = 1; i_rs1 = 0; i_rs1_used = 1;
        at_neg();
        chk("x0_stall", 32'(o_stall), 32'd0);
        chk("x0_pending", o_pending, 32'h0);
        step();

        // Saturation on x7
        clr(); i_id_valid = 1; i_rd = 7; i_rd_wr = 1;
        repeat (3) step();
        at_neg();
        chk("sat_stall", 32'(o_stall), 32'd1);
        chk("sat_pending", o_pending, 32'h0000_0080);
        step();
        i_rel_valid = 1; i_rel_rd = 7;
        at_neg(); chk("sat_rel_stall", 32'(o_stall), 32'd1);
        step();
        i_rel_valid = 0;
        at_neg(); chk("sat_issue", 32'(o_issue), 32'd1);
        step();
        clr(); i_rel_valid = 1; i_rel_rd = 7;
        repeat (3) step();
        clr();
        at_neg(); chk("sat_drained", 32'(o_busy), 32'd0);
        step();

        // Simultaneous issue and release on x9
        clr(); i_id_valid = 1; i_rd = 9; i_rd_wr = 1;
        step();
        i_rel_valid = 1; i_rel_rd = 9;
        at_neg(); chk("sim_issue", 32'(o_issue), 32'd1);
        step();
        clr();
        at_neg();
        chk("sim_busy", 32'(o_busy), 32'd1);
        chk("sim_pending", o_pending, 32'h0000_0200);
        i_rel_valid = 1; i_rel_rd = 9;
        step();
        clr();

        // Fence with x3 and x4 pending
        i_id_valid = 1; i_rd = 3; i_rd_wr = 1;
        step();
        i_rd = 4;
        step();
        clr(); a0 = acks;
        i_id_valid = 1; i_fence_req = 1;
        at_neg(); chk("fence_req_stall", 32'(o_stall), 32'd1);
        step();
        i_fence_req = 0; i_rel_valid = 1; i_rel_rd = 3;
        at_neg(); chk("fence_drain_stall", 32'(o_stall), 32'd1);
        step();
        i_rel_rd = 4;
        at_neg(); chk("fence_drain_ack", 32'(o_fence_ack), 32'd0);
        step();
        i_rel_valid = 0;
        at_neg();
        chk("fence_ack", 32'(o_fence_ack), 32'd1);
        chk("fence_ack_stall", 32'(o_stall), 32'd1);
        step();
        at_neg();
        chk("fence_done_ack", 32'(o_fence_ack), 32'd0);
        chk("fence_resume", 32'(o_issue), 32'd1);
        step();
        chk("fence_one_ack", 32'(acks - a0), 32'd1);

        // Empty fence held high: one pass through DRAIN, one ack
        clr(); a0 = acks; i_fence_req = 1;
        repeat (6) step();
        i_fence_req = 0;
        step();
        chk("hold_one_ack", 32'(acks - a0), 32'd1);

        // Underflow on x12
        clr(); i_rel_valid = 1; i_rel_rd = 12;
        at_neg(); chk("uf_before", 32'(o_underflow), 32'd0);
        step();
        clr();
        at_neg();
        chk("uf_set", 32'(o_underflow), 32'd1);
        chk("uf_pending", o_pending, 32'h0);
        step();

        // Reset in the middle of a drain
        i_id_valid = 1; i_rd = 3; i_rd_wr = 1;
        step();
        clr(); i_fence_req = 1;
        step();
        i_fence_req = 0;
        step();
        at_neg(); chk("mid_drain_ack", 32'(o_fence_ack), 32'd0);
        a0 = acks;
        rst = 1'b1;
        step();
        rst = 1'b0; i_id_valid = 1;
        at_neg();
        chk("rst2_pending", o_pending, 32'h0);
        chk("rst2_uf", 32'(o_underflow), 32'd0);
        chk("rst2_ack", 32'(o_fence_ack), 32'd0);
        chk("rst2_issue", 32'(o_issue), 32'd1);
        step();
        clr();
        repeat (3) step();
        chk("rst2_no_ack", 32'(acks - a0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
